uart_interface: RTL and testbench

UART_INTERFACE -- requirements
Module: uart_interface

---
 rtl/uart_bus_pkg.sv | 15 +
 rtl/uart_rx.sv | 77 +++++++
 rtl/uart_interface.sv | 161 ++++++++++++++++
 tb/tb_uart_interface.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: command bytes, bus control codes and FSM state types shared by the UART bus bridge
package uart_bus_pkg;
  localparam logic [7:0] CMD_WRITE      = 8'h56;
  localparam logic [7:0] CMD_READ       = 8'h55;
  localparam logic [7:0] CTRL_IDLE      = 8'h00;
  localparam logic [7:0] CTRL_WRITE     = 8'h01;
  localparam logic [7:0] CTRL_READ      = 8'h02;
  localparam logic [7:0] CTRL_SLAVE_ACK = 8'h80;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_WDATA, ST_BUS_REQ, ST_BUS_XFER, ST_TX_DATA
  } state_e;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_e;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte deserializer (clk, rst, rx_i serial in; data_o byte, valid_o one-cycle strobe)
module uart_rx
  import uart_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          rx_s;
  assign rx_s    = sync_q[1];
  assign data_o  = sh_q;
  assign valid_o = valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], rx_i};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        sh_d  = {rx_s, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == FULL) begin
        cnt_d   = '0;
        valid_d = rx_s;
        state_d = rx_s ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_interface.sv
// uart_interface: UART-commanded bus master (clk50MHz/rst; rx/tx serial; bus_req/bus_ack arbitration; bus_out/ctrl_out driven, bus_in/ctrl_in sampled)
module uart_interface
  import uart_bus_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int INPUT_CLOCK = 50000000,
  parameter int UART_BAUD   = 9600
) (
  input  logic                  clk50MHz,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  tx,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic [BUS_WIDTH-1:0]  bus_out,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  input  logic [CTRL_WIDTH-1:0] ctrl_in
);
  localparam int CLKS_PER_BIT = INPUT_CLOCK / UART_BAUD;
  localparam int TIMEOUT      = 16 * CLKS_PER_BIT;
  localparam int TW           = $clog2(TIMEOUT + 1);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  state_e                state_q, state_d;
  logic                  rd_q, rd_d;
  logic [1:0]            byte_q, byte_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [TW-1:0]         to_q, to_d;
  logic [7:0]            wait_q, wait_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [1:0]            tx_byte_q, tx_byte_d;
  logic                  tx_q, tx_d;
  logic                  bus_req_q, bus_req_d;
  logic [BUS_WIDTH-1:0]  bus_out_q, bus_out_d;
  logic [CTRL_WIDTH-1:0] ctrl_out_q, ctrl_out_d;
  logic [15:0]           frame;
  logic [7:0]            rx_byte;
  logic                  rx_valid;
  logic                  slave_ack;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk50MHz),
    .rst     (rst),
    .rx_i    (rx),
    .data_o  (rx_byte),
    .valid_o (rx_valid)
  );
  assign slave_ack = ctrl_in == CTRL_WIDTH'(CTRL_SLAVE_ACK);
  assign tx        = tx_q;
  assign bus_req   = bus_req_q;
  assign bus_out   = bus_out_q;
  assign ctrl_out  = ctrl_out_q;
  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= 1'b0;
      byte_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      to_q       <= '0;
      wait_q     <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
      bus_req_q  <= 1'b0;
      bus_out_q  <= '0;
      ctrl_out_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      byte_q     <= byte_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      to_q       <= to_d;
      wait_q     <= wait_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
      bus_req_q  <= bus_req_d;
      bus_out_q  <= bus_out_d;
      ctrl_out_q <= ctrl_out_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    byte_d     = byte_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    to_d       = to_q;
    wait_d     = wait_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    bus_out_d  = '0;
    ctrl_out_d = '0;
    unique case (state_q)
      ST_IDLE: if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
        state_d = ST_ADDR;
        rd_d    = rx_byte == CMD_READ;
        byte_d  = '0;
        to_d    = '0;
      end
      ST_ADDR, ST_WDATA: begin
        to_d = to_q + 1'b1;
        if (rx_valid) begin
          to_d   = '0;
          byte_d = byte_q + 1'b1;
          if (state_q == ST_ADDR) addr_d[{byte_q, 3'b000} +: 8] = rx_byte;
          else wdata_d[{byte_q, 3'b000} +: 8] = rx_byte;
          if (byte_q == 2'd3) state_d = (state_q == ST_WDATA || rd_q) ? ST_BUS_REQ : ST_WDATA;
        end else if (to_q == TW'(TIMEOUT - 1)) state_d = ST_IDLE;
      end
      ST_BUS_REQ: if (bus_ack) begin
        state_d    = ST_BUS_XFER;
        bus_out_d  = BUS_WIDTH'(addr_q);
        ctrl_out_d = rd_q ? CTRL_WIDTH'(CTRL_READ) : CTRL_WIDTH'(CTRL_WRITE);
        wait_d     = '0;
      end
      ST_BUS_XFER: begin
        // wait_q doubles as the write phase flag and the read response timer
        if (!bus_ack) state_d = ST_IDLE;
        else if (!rd_q) begin
          if (wait_q == 8'd0) begin
            bus_out_d  = BUS_WIDTH'(wdata_q);
            ctrl_out_d = CTRL_WIDTH'(CTRL_WRITE);
            wait_d     = 8'd1;
          end else state_d = ST_IDLE;
        end else if (slave_ack || wait_q == 8'hFF) begin
          state_d   = ST_TX_DATA;
          rdata_d   = slave_ack ? 32'(bus_in) : 32'hFFFF_FFFF;
          tx_cnt_d  = '0;
          tx_bit_d  = '0;
          tx_byte_d = '0;
        end else wait_d = wait_q + 1'b1;
      end
      ST_TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt_d = '0;
          tx_bit_d = (tx_bit_q == 4'd10) ? 4'd0 : tx_bit_q + 1'b1;
          if (tx_bit_q == 4'd10) tx_byte_d = tx_byte_q + 1'b1;
          if (tx_byte_q == 2'd3 && tx_bit_q == 4'd9) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // bit slots per byte: 0 start, 1-8 data, 9 stop, 10 inter-byte idle
    frame     = {7'h7F, rdata_d[{tx_byte_d, 3'b000} +: 8], 1'b0};
    tx_d      = (state_d == ST_TX_DATA) ? frame[tx_bit_d] : 1'b1;
    bus_req_d = state_d == ST_BUS_REQ || state_d == ST_BUS_XFER;
  end
endmodule

// File: tb/tb_uart_interface.sv
// tb_uart_interface: directed self-checking bench for uart_interface
module tb_uart_interface;
  import uart_bus_pkg::*;
  localparam int CPB = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_in = '0;
  logic [7:0]  ctrl_in = '0;
  logic        tx, bus_req;
  logic [31:0] bus_out;
  logic [7:0]  ctrl_out;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_interface #(.BUS_WIDTH(32), .CTRL_WIDTH(8), .INPUT_CLOCK(160), .UART_BAUD(10)) dut (
    .clk50MHz (clk),
    .rst      (rst),
    .rx       (rx),
    .tx       (tx),
    .bus_req  (bus_req),
    .bus_ack  (bus_ack),
    .bus_out  (bus_out),
    .bus_in   (bus_in),
    .ctrl_out (ctrl_out),
    .ctrl_in  (ctrl_in)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask
  task automatic wait_req();
    int n = 0;
    while (bus_req !== 1'b1 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("bus_req_raise", bus_req, 1);
  endtask
  task automatic check_write(input logic [31:0] a, input logic [31:0] d);
    wait_req();
    chk("wr_pre_bus", bus_out, 0);
    chk("wr_pre_ctrl", ctrl_out, 0);
    bus_ack = 1'b1;
    @(negedge clk);
    chk("wr_addr", bus_out, a);
    chk("wr_ctrl_addr", ctrl_out, 32'h01);
    @(negedge clk);
    chk("wr_data", bus_out, d);
    chk("wr_ctrl_data", ctrl_out, 32'h01);
    @(negedge clk);
    chk("wr_done_req", bus_req, 0);
    chk("wr_done_bus", bus_out, 0);
    chk("wr_done_ctrl", ctrl_out, 0);
    bus_ack = 1'b0;
  endtask
  task automatic recv_tx(output logic [7:0] b, output int t);
    int n = 0;
    b = '0;
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    repeat (CPB / 2) @(negedge clk);
    chk("tx_start", tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    chk("tx_stop", tx, 1);
  endtask
  task automatic expect_tx(input logic [31:0] w);
    logic [7:0] b;
    int t;
    int t0 = 0;
    for (int k = 0; k < 4; k++) begin
      recv_tx(b, t);
      chk("tx_byte", b, w[8*k +: 8]);
      if (k > 0) chk("tx_byte_period", t - t0, 11 * CPB);
      t0 = t;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_tx", tx, 1);
    chk("rst_bus", bus_out, 0);
    chk("rst_ctrl", ctrl_out, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_word(32'h0000_0001);
    send_word(32'h00FF_00FF);
    check_write(32'h0000_0001, 32'h00FF_00FF);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h55, 1'b1);
    send_word(32'h0000_0001);
    wait_req();
    chk("rd_pre_ctrl", ctrl_out, 0);
    bus_ack = 1'b1;
    @(negedge clk);
    chk("rd_addr", bus_out, 32'h0000_0001);
    chk("rd_ctrl", ctrl_out, 32'h02);
    ctrl_in = 8'h80;
    bus_in  = 32'h00FF_00FF;
    @(negedge clk);
    chk("rd_req_drop", bus_req, 0);
    chk("rd_ctrl_idle", ctrl_out, 0);
    bus_ack = 1'b0;
    ctrl_in = 8'h00;
    bus_in  = 32'hDEAD_BEEF;
    expect_tx(32'h00FF_00FF);
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h12, 1'b1);
    chk("junk_ignored", dut.state_q, ST_IDLE);
    send_byte(8'h56, 1'b1);
    send_word(32'hA5A5_0F0F);
    send_word(32'h1234_5678);
    check_write(32'hA5A5_0F0F, 32'h1234_5678);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_byte(8'hAB, 1'b0);
    chk("fe_state", dut.state_q, ST_ADDR);
    chk("fe_byte_idx", dut.byte_q, 0);
    repeat (20 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (20 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_word(32'h4433_2211);
    send_word(32'hDDCC_BBAA);
    check_write(32'h4433_2211, 32'hDDCC_BBAA);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_word(32'hCAFE_0001);
    send_word(32'h0BAD_0002);
    wait_req();
    bus_ack = 1'b1;
    @(negedge clk);
    chk("ab_addr", bus_out, 32'hCAFE_0001);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("ab_req", bus_req, 0);
    chk("ab_bus", bus_out, 0);
    chk("ab_ctrl", ctrl_out, 0);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h55, 1'b1);
    send_word(32'h0000_0010);
    wait_req();
    bus_ack = 1'b1;
    @(negedge clk);
    chk("to_addr", bus_out, 32'h0000_0010);
    chk("to_ctrl_rd", ctrl_out, 32'h02);
    repeat (255) @(negedge clk);
    chk("to_req_held", bus_req, 1);
    chk("to_ctrl_wait", ctrl_out, 0);
    chk("to_tx_idle", tx, 1);
    @(negedge clk);
    chk("to_req_drop", bus_req, 0);
    bus_ack = 1'b0;
    expect_tx(32'hFFFF_FFFF);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_word(32'h0102_0304);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hEE, 1'b1);
    chk("rr_pre_state", dut.state_q, ST_WDATA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_req", bus_req, 0);
    chk("rr_tx", tx, 1);
    chk("rr_state", dut.state_q, ST_IDLE);
    chk("rr_addr", dut.addr_q, 0);
    chk("rr_wdata", dut.wdata_q, 0);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h56, 1'b1);
    send_word(32'h5566_7788);
    send_word(32'h99AA_BBCC);
    check_write(32'h5566_7788, 32'h99AA_BBCC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
